// File: rtl/bias_loader.sv
// Double-buffered bias vector loader: bytes arrive serially into a shadow
// register and are committed to the active bank `b` on a `swap` strobe.
module bias_loader #(
    parameter int SIZE = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              swap,
    input  logic              flush,
    output logic [8*SIZE-1:0] b,
    output logic              b_valid,
    output logic              shadow_full,
    output logic              swap_miss,
    output logic              state_dbg_o
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [8*SIZE-1:0]   shadow_q;
    logic [8*SIZE-1:0]   b_q;
    logic                b_valid_q;
    logic                swap_miss_q;
    logic [CW-1:0]       lane_d;
    logic                last_d;

    // First byte of a vector lands in the most significant lane.
    assign lane_d = CW'(SIZE - 1) - cnt_q;
    assign last_d = (cnt_q == CW'(SIZE - 1));

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on the state register, never on in_valid.
    assign in_ready    = (state_q == LOAD);
    assign shadow_full = (state_q == FULL);
    assign b           = b_q;
    assign b_valid     = b_valid_q;
    assign swap_miss   = swap_miss_q;
    assign state_dbg_o = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            shadow_q    <= '0;
            b_q         <= '0;
            b_valid_q   <= 1'b0;
            swap_miss_q <= 1'b0;
        end else begin
            swap_miss_q <= 1'b0;
            if (flush) begin
                // Flush beats both swap and any byte offered this cycle.
                state_q <= LOAD;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    LOAD: begin
                        if (swap) begin
                            swap_miss_q <= 1'b1;
                        end
                        if (in_valid) begin
                            for (int k = 0; k < SIZE; k++) begin
                                if (k == int'(lane_d)) begin
                                    shadow_q[8*k +: 8] <= in_data;
                                end
                            end
                            if (last_d) begin
                                cnt_q   <= '0;
                                state_q <= FULL;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    FULL: begin
                        if (swap) begin
                            b_q       <= shadow_q;
                            b_valid_q <= 1'b1;
                            state_q   <= LOAD;
                        end
                    end
                    default: begin
                        state_q <= LOAD;
                    end
                endcase
            end
        end
    end

endmodule
